// File: rtl/cpu_pkg.sv
// Shared control-word types for the CPU sequencer and its datapath.
// Helper functions compose the common bus-cycle patterns onto a control word.
package cpu_pkg;

    typedef enum logic       {PC_SAME, PC_INC_OUT} pc_next_e;
    typedef enum logic [2:0] {RS_A, RS_8SRC, RS_8DST, RS_Z, RS_W, RS_C, RS_16LO, RS_16HI} reg_sel_e;
    typedef enum logic [1:0] {ROP_NONE, ROP_WRITE_ALU, ROP_WRITE_MEM} reg_op_e;
    typedef enum logic [1:0] {INC_NONE, INC_INC, INC_DEC} inc_op_e;
    typedef enum logic [1:0] {IR_PC, IR_HL, IR_INST16, IR_WZ} inc_reg_e;
    typedef enum logic [2:0] {ALU_COPY_A, ALU_COPY_B, ALU_INST, ALU_ADD_LO, ALU_ADD_HI, ALU_INC_A} alu_op_e;
    typedef enum logic       {SA_REG_A, SA_REG1} alu_sel_a_e;
    typedef enum logic       {SB_REG2, SB_ZERO} alu_sel_b_e;
    typedef enum logic       {FLAG_NONE, FLAG_ALL} alu_flag_set_e;
    typedef enum logic       {MA_INC, MA_HIGH} mem_addr_sel_e;

    typedef struct packed {
        pc_next_e      pc_next;
        logic          inst_load;
        reg_sel_e      reg_read1_sel;
        reg_sel_e      reg_read2_sel;
        reg_sel_e      reg_write_sel;
        reg_op_e       reg_op;
        inc_op_e       inc_op;
        inc_reg_e      inc_reg;
        alu_op_e       alu_op;
        alu_sel_a_e    alu_sel_a;
        alu_sel_b_e    alu_sel_b;
        alu_flag_set_e alu_flag_set;
        logic          mem_enable;
        logic          mem_write;
        mem_addr_sel_e mem_addr_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        pc_next: PC_SAME, inst_load: 1'b0, reg_read1_sel: RS_A, reg_read2_sel: RS_A,
        reg_write_sel: RS_A, reg_op: ROP_NONE, inc_op: INC_NONE, inc_reg: IR_PC,
        alu_op: ALU_COPY_A, alu_sel_a: SA_REG_A, alu_sel_b: SB_REG2,
        alu_flag_set: FLAG_NONE, mem_enable: 1'b0, mem_write: 1'b0, mem_addr_sel: MA_INC};

    function automatic ctrl_t f_fetch(input ctrl_t c);
        ctrl_t r = c;
        r.mem_enable = 1'b1;
        r.inc_reg    = IR_PC;
        r.inc_op     = INC_INC;
        r.pc_next    = PC_INC_OUT;
        r.inst_load  = 1'b1;
        return r;
    endfunction

    function automatic ctrl_t f_rd(input ctrl_t c, input inc_reg_e src, input reg_sel_e dst);
        ctrl_t r = c;
        r.mem_enable    = 1'b1;
        r.inc_reg       = src;
        r.reg_op        = ROP_WRITE_MEM;
        r.reg_write_sel = dst;
        return r;
    endfunction

    function automatic ctrl_t f_rdpc(input ctrl_t c, input reg_sel_e dst);
        ctrl_t r = f_rd(c, IR_PC, dst);
        r.inc_op  = INC_INC;
        r.pc_next = PC_INC_OUT;
        return r;
    endfunction

    function automatic ctrl_t f_wr(input ctrl_t c);
        ctrl_t r = c;
        r.mem_enable = 1'b1;
        r.mem_write  = 1'b1;
        return r;
    endfunction

    // Accumulator ALU op; the datapath takes the operation from opcode bits 5:3.
    function automatic ctrl_t f_alu(input ctrl_t c, input logic [2:0] op3, input reg_sel_e rd2);
        ctrl_t r = c;
        r.alu_op        = ALU_INST;
        r.alu_sel_a     = SA_REG_A;
        r.reg_read2_sel = rd2;
        r.alu_flag_set  = FLAG_ALL;
        r.reg_write_sel = RS_A;
        r.reg_op        = (op3 == 3'b111) ? ROP_NONE : ROP_WRITE_ALU;
        return r;
    endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Control bus between the CPU sequencer (master) and the datapath (slave).
interface cpu_control_if;
    import cpu_pkg::*;

    logic [1:0]    t_cycle;
    logic [7:0]    mem_data_in;
    logic          condition;
    pc_next_e      pc_next;
    logic          inst_load;
    reg_sel_e      reg_read1_sel;
    reg_sel_e      reg_read2_sel;
    reg_sel_e      reg_write_sel;
    reg_op_e       reg_op;
    inc_op_e       inc_op;
    inc_reg_e      inc_reg;
    alu_op_e       alu_op;
    alu_sel_a_e    alu_sel_a;
    alu_sel_b_e    alu_sel_b;
    alu_flag_set_e alu_flag_set;
    logic          mem_enable;
    logic          mem_write;
    mem_addr_sel_e mem_addr_sel;

    modport master (
        input  t_cycle, mem_data_in, condition,
        output pc_next, inst_load, reg_read1_sel, reg_read2_sel, reg_write_sel, reg_op,
               inc_op, inc_reg, alu_op, alu_sel_a, alu_sel_b, alu_flag_set,
               mem_enable, mem_write, mem_addr_sel
    );

    modport slave (
        output t_cycle, mem_data_in, condition,
        input  pc_next, inst_load, reg_read1_sel, reg_read2_sel, reg_write_sel, reg_op,
               inc_op, inc_reg, alu_op, alu_sel_a, alu_sel_b, alu_flag_set,
               mem_enable, mem_write, mem_addr_sel
    );

endinterface

// File: rtl/cpu_control_decode.sv
// Combinational decode of {opcode, M-cycle step, condition} into one control word.
// The last step of every instruction is the fetch, so o_last follows inst_load.
module cpu_control_decode
    import cpu_pkg::*;
(
    input  logic [7:0] i_opcode,
    input  logic [1:0] i_step,
    input  logic       i_condition,
    output ctrl_t      o_ctrl,
    output logic       o_last
);

    ctrl_t w_c;
    logic  w_s0;
    logic  w_s1;

    assign w_s0 = (i_step == 2'd0);
    assign w_s1 = (i_step == 2'd1);

    always_comb begin
        w_c = CTRL_DEFAULT;
        casez (i_opcode)
            8'h76: w_c = f_fetch(w_c);
            8'h36: begin
                if (w_s0) w_c = f_rdpc(w_c, RS_Z);
                else if (w_s1) begin
                    w_c = f_wr(w_c);
                    w_c.inc_reg       = IR_HL;
                    w_c.alu_op        = ALU_COPY_B;
                    w_c.reg_read2_sel = RS_Z;
                end else w_c = f_fetch(w_c);
            end
            8'h22, 8'h32: begin
                if (w_s0) begin
                    w_c = f_wr(w_c);
                    w_c.inc_reg = IR_HL;
                    w_c.inc_op  = i_opcode[4] ? INC_DEC : INC_INC;
                end else w_c = f_fetch(w_c);
            end
            8'h2A, 8'h3A: begin
                if (w_s0) begin
                    w_c = f_rd(w_c, IR_HL, RS_A);
                    w_c.inc_op = i_opcode[4] ? INC_DEC : INC_INC;
                end else w_c = f_fetch(w_c);
            end
            8'hE0, 8'hF0, 8'hE2, 8'hF2: begin
                // The (n) forms read the offset first; the (C) forms go straight to the access.
                if (w_s0 && !i_opcode[1]) w_c = f_rdpc(w_c, RS_Z);
                else if ((w_s1 && !i_opcode[1]) || (w_s0 && i_opcode[1])) begin
                    w_c = i_opcode[4] ? f_rd(w_c, IR_PC, RS_A) : f_wr(w_c);
                    w_c.mem_addr_sel  = MA_HIGH;
                    w_c.reg_read2_sel = i_opcode[1] ? RS_C : RS_Z;
                end else w_c = f_fetch(w_c);
            end
            8'hC3, 8'b110??010: begin
                if (w_s0) w_c = f_rdpc(w_c, RS_Z);
                else if (w_s1) w_c = f_rdpc(w_c, RS_W);
                else if (i_step == 2'd2 && (i_opcode[0] || i_condition)) begin
                    w_c.inc_reg = IR_WZ;
                    w_c.pc_next = PC_INC_OUT;
                end else w_c = f_fetch(w_c);
            end
            8'b01110???: begin
                if (w_s0) begin
                    w_c = f_wr(w_c);
                    w_c.inc_reg       = IR_HL;
                    w_c.alu_op        = ALU_COPY_B;
                    w_c.reg_read2_sel = RS_8SRC;
                end else w_c = f_fetch(w_c);
            end
            8'b01???110: w_c = w_s0 ? f_rd(w_c, IR_HL, RS_8DST) : f_fetch(w_c);
            8'b01??????: begin
                w_c = f_fetch(w_c);
                w_c.alu_op        = ALU_COPY_B;
                w_c.reg_read2_sel = RS_8SRC;
                w_c.reg_op        = ROP_WRITE_ALU;
                w_c.reg_write_sel = RS_8DST;
            end
            8'b10???110: w_c = w_s0 ? f_rd(w_c, IR_HL, RS_Z)
                                    : f_alu(f_fetch(w_c), i_opcode[5:3], RS_Z);
            8'b10??????: w_c = f_alu(f_fetch(w_c), i_opcode[5:3], RS_8SRC);
            8'b11???110: w_c = w_s0 ? f_rdpc(w_c, RS_Z)
                                    : f_alu(f_fetch(w_c), i_opcode[5:3], RS_Z);
            8'b00???110: w_c = w_s0 ? f_rdpc(w_c, RS_8DST) : f_fetch(w_c);
            8'b00??0001: begin
                if (w_s0) w_c = f_rdpc(w_c, RS_16LO);
                else if (w_s1) w_c = f_rdpc(w_c, RS_16HI);
                else w_c = f_fetch(w_c);
            end
            8'b00???011: begin
                if (w_s0) begin
                    w_c.inc_reg = IR_INST16;
                    w_c.inc_op  = i_opcode[3] ? INC_DEC : INC_INC;
                end else w_c = f_fetch(w_c);
            end
            default: w_c = f_fetch(w_c);
        endcase
    end

    assign o_ctrl = w_c;
    assign o_last = w_c.inst_load;

endmodule

// File: rtl/cpu_control.sv
// CPU instruction sequencer: latched opcode plus M-cycle step, advanced once per
// M-cycle on the t_cycle 3 edge; outputs are decoded from that state.
module cpu_control
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    cpu_control_if.master bus
);

    logic [7:0] r_opcode;
    logic [1:0] r_step;
    ctrl_t      w_ctrl;
    logic       w_last;

    cpu_control_decode u_decode (
        .i_opcode    (r_opcode),
        .i_step      (r_step),
        .i_condition (bus.condition),
        .o_ctrl      (w_ctrl),
        .o_last      (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode <= 8'h00;
            r_step   <= 2'd0;
        end else if (bus.t_cycle == 2'd3) begin
            if (w_last) begin
                r_opcode <= bus.mem_data_in;
                r_step   <= 2'd0;
            end else begin
                r_step   <= r_step + 2'd1;
            end
        end
    end

    assign bus.pc_next       = w_ctrl.pc_next;
    assign bus.inst_load     = w_ctrl.inst_load;
    assign bus.reg_read1_sel = w_ctrl.reg_read1_sel;
    assign bus.reg_read2_sel = w_ctrl.reg_read2_sel;
    assign bus.reg_write_sel = w_ctrl.reg_write_sel;
    assign bus.reg_op        = w_ctrl.reg_op;
    assign bus.inc_op        = w_ctrl.inc_op;
    assign bus.inc_reg       = w_ctrl.inc_reg;
    assign bus.alu_op        = w_ctrl.alu_op;
    assign bus.alu_sel_a     = w_ctrl.alu_sel_a;
    assign bus.alu_sel_b     = w_ctrl.alu_sel_b;
    assign bus.alu_flag_set  = w_ctrl.alu_flag_set;
    assign bus.mem_enable    = w_ctrl.mem_enable;
    assign bus.mem_write     = w_ctrl.mem_write;
    assign bus.mem_addr_sel  = w_ctrl.mem_addr_sel;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: walks opcodes M-cycle by M-cycle and checks
// the decoded control word against hand-derived values.
module tb_cpu_control;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    cpu_control_if bus();

    cpu_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_fetch(input string tag);
        check({tag, "_inst_load"}, 32'(bus.inst_load), 32'd1);
        check({tag, "_pc_next"},   32'(bus.pc_next), 32'(PC_INC_OUT));
        check({tag, "_mem_en"},    32'(bus.mem_enable), 32'd1);
        check({tag, "_mem_wr"},    32'(bus.mem_write), 32'd0);
        check({tag, "_inc_op"},    32'(bus.inc_op), 32'(INC_INC));
        check({tag, "_inc_reg"},   32'(bus.inc_reg), 32'(IR_PC));
    endtask

    // One M-cycle: four T-cycle edges with bus data held constant; returns #1 after the t3 edge.
    task automatic m_cycle(input logic [7:0] d, input logic c);
        for (int t = 0; t < 4; t++) begin
            bus.t_cycle     = 2'(t);
            bus.mem_data_in = d;
            bus.condition   = c;
            @(posedge clk);
            #1;
        end
        bus.t_cycle = 2'd0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.t_cycle     = 2'd0;
        bus.mem_data_in = 8'hFF;
        bus.condition   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_opcode", 32'(dut.r_opcode), 32'h00);
        check("rst_step",   32'(dut.r_step), 32'd0);
        reset = 1'b0;
        check_fetch("rst_m1");

        m_cycle(8'h00, 1'b0);
        check_fetch("nop_m1");

        // LD B,n
        m_cycle(8'h06, 1'b0);
        check("ldrn_m1_rop",   32'(bus.reg_op), 32'(ROP_WRITE_MEM));
        check("ldrn_m1_wsel",  32'(bus.reg_write_sel), 32'(RS_8DST));
        check("ldrn_m1_pc",    32'(bus.pc_next), 32'(PC_INC_OUT));
        check("ldrn_m1_iload", 32'(bus.inst_load), 32'd0);
        m_cycle(8'h55, 1'b0);
        check_fetch("ldrn_m2");

        // CP B
        m_cycle(8'hB8, 1'b0);
        check("cp_alu",   32'(bus.alu_op), 32'(ALU_INST));
        check("cp_flag",  32'(bus.alu_flag_set), 32'(FLAG_ALL));
        check("cp_rop",   32'(bus.reg_op), 32'(ROP_NONE));
        check("cp_rd2",   32'(bus.reg_read2_sel), 32'(RS_8SRC));
        check("cp_iload", 32'(bus.inst_load), 32'd1);

        // JP NZ,nn not taken
        m_cycle(8'hC2, 1'b0);
        check("jpf_m1_wsel", 32'(bus.reg_write_sel), 32'(RS_Z));
        m_cycle(8'h34, 1'b0);
        check("jpf_m2_wsel", 32'(bus.reg_write_sel), 32'(RS_W));
        m_cycle(8'h12, 1'b0);
        check_fetch("jpf_m3");

        // JP NZ,nn taken
        m_cycle(8'hC2, 1'b0);
        m_cycle(8'h34, 1'b1);
        m_cycle(8'h12, 1'b1);
        check("jpt_m3_increg", 32'(bus.inc_reg), 32'(IR_WZ));
        check("jpt_m3_pc",     32'(bus.pc_next), 32'(PC_INC_OUT));
        check("jpt_m3_incop",  32'(bus.inc_op), 32'(INC_NONE));
        check("jpt_m3_iload",  32'(bus.inst_load), 32'd0);
        check("jpt_m3_memen",  32'(bus.mem_enable), 32'd0);
        m_cycle(8'h00, 1'b1);
        check_fetch("jpt_m4");

        // LDH (n),A
        m_cycle(8'hE0, 1'b0);
        check("ldh_m1_wsel", 32'(bus.reg_write_sel), 32'(RS_Z));
        m_cycle(8'h80, 1'b0);
        check("ldh_m2_wr",   32'(bus.mem_write), 32'd1);
        check("ldh_m2_addr", 32'(bus.mem_addr_sel), 32'(MA_HIGH));
        check("ldh_m2_rd2",  32'(bus.reg_read2_sel), 32'(RS_Z));
        check("ldh_m2_alu",  32'(bus.alu_op), 32'(ALU_COPY_A));
        m_cycle(8'h77, 1'b0);
        check_fetch("ldh_m3");

        // LD r,r' (LD B,C) then INC HL
        m_cycle(8'h41, 1'b0);
        check("ldrr_alu",  32'(bus.alu_op), 32'(ALU_COPY_B));
        check("ldrr_rop",  32'(bus.reg_op), 32'(ROP_WRITE_ALU));
        check("ldrr_wsel", 32'(bus.reg_write_sel), 32'(RS_8DST));
        check("ldrr_iload", 32'(bus.inst_load), 32'd1);
        m_cycle(8'h23, 1'b0);
        check("inc16_reg",   32'(bus.inc_reg), 32'(IR_INST16));
        check("inc16_op",    32'(bus.inc_op), 32'(INC_INC));
        check("inc16_iload", 32'(bus.inst_load), 32'd0);
        m_cycle(8'h00, 1'b0);
        check_fetch("inc16_m2");

        // LD BC,nn, then reset in M2
        m_cycle(8'h01, 1'b0);
        check("ldrr16_m1_wsel", 32'(bus.reg_write_sel), 32'(RS_16LO));
        for (int t = 0; t < 3; t++) begin
            bus.t_cycle     = 2'(t);
            bus.mem_data_in = 8'hAA;
            @(posedge clk);
            #1;
        end
        check("hold_t012_step", 32'(dut.r_step), 32'd0);
        check("hold_t012_wsel", 32'(bus.reg_write_sel), 32'(RS_16LO));
        bus.t_cycle = 2'd3;
        @(posedge clk);
        #1;
        bus.t_cycle = 2'd0;
        check("ldrr16_m2_wsel", 32'(bus.reg_write_sel), 32'(RS_16HI));
        bus.t_cycle = 2'd1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.t_cycle = 2'd0;
        check("midrst_step",   32'(dut.r_step), 32'd0);
        check("midrst_opcode", 32'(dut.r_opcode), 32'h00);
        check_fetch("midrst_m1");
        m_cycle(8'h00, 1'b0);
        check_fetch("midrst_m2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Ports, one per line (name  direction  width  meaning):
- clk  in  1  clock; one T-cycle per rising edge.
- reset  in  1  synchronous, active-high reset.
- t_cycle  in  2  T-cycle index 0..3 within the M-cycle; it wraps 3->0.
- mem_data_in  in  8  bus read data, valid at t_cycle 3.
- condition  in  1  branch condition for the current opcode's cc field (bits 4:3).
- pc_next  out  pc_next_e  PC update select.
- inst_load  out  1  load the next opcode at t_cycle 3.
- reg_read1_sel, reg_read2_sel, reg_write_sel  out  reg_sel_e  register-file selects.
- reg_op  out  reg_op_e  register write source.
- inc_op  out  inc_op_e  16-bit incrementer operation.
- inc_reg  out  inc_reg_e  incrementer target.
- alu_op  out  alu_op_e  ALU operation.
- alu_sel_a  out  alu_sel_a_e  ALU operand A source.
- alu_sel_b  out  alu_sel_b_e  ALU operand B source.
- alu_flag_set  out  alu_flag_set_e  flag update mode.
- mem_enable  out  1  bus access this M-cycle.
- mem_write  out  1  bus write; write data is the ALU output.
- mem_addr_sel  out  mem_addr_sel_e  address source: Incrementer input or 0xFF00|reg2.

Function
REQ-004 State SHALL be a latched opcode (8 bits) and an M-cycle step counter (2 bits); both update only on the clock edge where t_cycle==3.
REQ-005 Outputs SHALL be combinational from {opcode, step, condition} and held for the whole M-cycle.
REQ-006 Output defaults:
- pc_next=Same, inst_load=0, reg_op=None, inc_op=None, inc_reg=PC.
- alu_op=CopyA, alu_sel_a=RegA, alu_sel_b=Reg2, alu_flag_set=None.
- mem_enable=0, mem_write=0, mem_addr_sel=Incrementer, all selects=RegSelA.
REQ-007 FETCH SHALL set mem_enable=1, inc_reg=PC, inc_op=Inc, pc_next=IncOut and inst_load=1. At t_cycle 3 the opcode latches mem_data_in and the step counter returns to 0.
REQ-008 RD(src->dst) SHALL be a memory read at the source address with reg_op=WriteMem into dst. RDPC(dst) SHALL be RD at PC with inc_op=Inc and pc_next=IncOut.
REQ-009 WR(addr) SHALL set mem_enable=1 and mem_write=1; the data selection is stated per instruction.
REQ-010 Otherwise the step counter SHALL increment at t_cycle 3.
REQ-011 Instruction sequences, M1..Mn:
- NOP, 0x76, and every opcode not listed here: FETCH.
- LD r,r' (01dddsss): FETCH plus alu CopyB, read2=Reg8Src, WriteAlu into Reg8Dest.
- LD r,n (00ddd110): RDPC(Reg8Dest); FETCH.
- LD (HL),n (0x36): RDPC(Z); WR(HL) with CopyB, read2=Z; FETCH.
- LD r,(HL) (01ddd110): RD(HL->Reg8Dest); FETCH.
- LD (HL),r (01110sss): WR(HL) with CopyB, read2=Reg8Src; FETCH.
- LD (HL+/-),A (0x22/0x32): WR(HL) with CopyA, inc_reg=HL, inc_op=Inc/Dec; FETCH.
- LD A,(HL+/-) (0x2A/0x3A): RD(HL->A) with inc_op=Inc/Dec; FETCH.
- ALU A,r (10ooosss): FETCH plus InstAlu, sel_a=RegA, read2=Reg8Src, flag_set=All, WriteAlu into A. When ooo=111 (CP), reg_op=None.
- ALU A,(HL) (10ooo110): RD(HL->Z); FETCH plus the ALU A,r controls with read2=Z.
- ALU A,n (11ooo110): RDPC(Z); FETCH plus the ALU A,r controls with read2=Z.
- LD rr,nn (00rr0001): RDPC(Reg16Lo); RDPC(Reg16Hi); FETCH.
- INC/DEC rr (00rr0011/00rr1011): inc_reg=Inst16, inc_op=Inc/Dec; FETCH.
- LDH (n),A / LDH A,(n) (0xE0/0xF0): RDPC(Z); then mem_addr_sel=High, read2=Z, with either WR using CopyA or RD into A; FETCH.
- LD (C),A / LD A,(C) (0xE2/0xF2): mem_addr_sel=High, read2=C, with either WR using CopyA or RD into A; FETCH.
- JP nn (0xC3): RDPC(Z); RDPC(W); inc_reg=WZ, inc_op=None, pc_next=IncOut; FETCH. Total 4 M-cycles.
- JP cc,nn (110cc010): same as JP nn when condition=1 (4 M-cycles). When condition=0, M3 SHALL be FETCH (3 M-cycles). condition is sampled in M3.
REQ-012 alu_op values AddLo, AddHi and IncA SHALL exist in the package but are never driven by this block.

Reset
REQ-013 While reset is high at a clock edge, opcode SHALL become 0x00 and step SHALL become 0, at any t_cycle. Reset has priority over all updates.
REQ-014 After reset, the first M-cycle SHALL be FETCH at PC. Reset applied mid-instruction SHALL abandon that instruction.

Structure
REQ-015 The enums pc_next_e, reg_sel_e, reg_op_e, inc_op_e, inc_reg_e, alu_op_e, alu_sel_a_e, alu_sel_b_e, alu_flag_set_e and mem_addr_sel_e SHALL live in a shared package cpu_pkg.
REQ-016 The block SHALL have one combinational sub-module, cpu_control_decode, mapping {opcode, step, condition} to outputs plus a last-step flag. The sequencer registers SHALL be in the top module.

Verification
REQ-017 Reset, then mem_data_in=0x00 -> every M-cycle is FETCH, with inst_load=1 and pc_next=IncOut.
REQ-018 Opcode 0x06 -> M1: reg_op=WriteMem, reg_write_sel=Reg8Dest, pc_next=IncOut. M2: FETCH.
REQ-019 Opcode 0xB8 (CP B) -> one M-cycle with alu_op=InstAlu, flag_set=All, reg_op=None.
REQ-020 Opcode 0xC2 -> with condition=0: M3=FETCH. With condition=1: M3 has inc_reg=WZ, pc_next=IncOut, and M4=FETCH.
REQ-021 Opcode 0xE0 -> M2: mem_write=1, mem_addr_sel=High, reg_read2_sel=Z.
REQ-022 Assert reset during M2 of 0x01 -> the next M-cycle is FETCH, with step and opcode cleared.
